odo_sbox6_arbiter: RTL and testbench

- Shares one 6-bit registered S-box lookup (64-entry table, 1-cycle latency) between NREQ independent requesters.
- Uses round-robin arbitration and per-requester valid/ready request and response channels.
- Sits between the Odo round-function lanes and a single S-box instance, so several lanes can use one table instead of replicating it.
- Sustains one lookup per cycle in aggregate, and at most one outstanding lookup per requester.

---
 rtl/odo_sbox6_arbiter.sv | 144 ++++++++++++++
 tb/tb_odo_sbox6_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/odo_sbox6_arbiter.sv
// odo_sbox6_arbiter
// Shares one registered 6-bit S-box (1-cycle latency) between NREQ requesters.
// Request side: round-robin grant among eligible requesters, at most one per cycle.
// Response side: one held slot per requester, released by rsp_ready.
// Stage p0 is the combinational grant/address cycle; stage p1 is the cycle the
// S-box result returns and is written into the granted requester's slot.
module odo_sbox6_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [6*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [6*NREQ-1:0] rsp_data,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [5:0]        sbox_in,
    input  logic [5:0]        sbox_out,
    output logic              busy,
    output logic [CNTW-1:0]   lookup_cnt
);

    // Lookup in flight at the S-box: valid flag and owning requester.
    logic            vld_p1;
    logic [IDW-1:0]  id_p1;

    // Round-robin search start for the next grant.
    logic [IDW-1:0]  rr_ptr;

    // Grant decision for the current cycle.
    logic [NREQ-1:0] eligible;
    logic            gnt_vld_p0;
    logic [IDW-1:0]  gnt_id_p0;
    logic [IDW:0]    cand_p0;
    logic [IDW-1:0]  rr_next;

    // A requester may be granted when its slot is free (or freeing this cycle)
    // and it does not already own the lookup in flight.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = req_valid[i]
                       && (!rsp_valid[i] || rsp_ready[i])
                       && !(vld_p1 && (id_p1 == IDW'(i)));
        end
    end

    // ---- stage p0: round-robin grant, scanning rr_ptr, rr_ptr+1, ... mod NREQ ----
    // Suppressed by clear and while reset is held so nothing leaks out.
    always_comb begin
        gnt_vld_p0 = 1'b0;
        gnt_id_p0  = '0;
        cand_p0    = '0;
        for (int off = 0; off < NREQ; off++) begin
            cand_p0 = {1'b0, rr_ptr} + (IDW+1)'(off);
            if (cand_p0 >= (IDW+1)'(NREQ)) begin
                cand_p0 = cand_p0 - (IDW+1)'(NREQ);
            end
            if (!gnt_vld_p0 && eligible[cand_p0[IDW-1:0]]) begin
                gnt_vld_p0 = 1'b1;
                gnt_id_p0  = cand_p0[IDW-1:0];
            end
        end
        if (clear || !rst_n) begin
            gnt_vld_p0 = 1'b0;
            gnt_id_p0  = '0;
        end
    end

    // Pointer moves just past the granted requester, wrapping at NREQ.
    always_comb begin
        if (gnt_id_p0 == IDW'(NREQ - 1)) begin
            rr_next = '0;
        end else begin
            rr_next = gnt_id_p0 + IDW'(1);
        end
    end

    // One-hot ready and the S-box address of the granted requester.
    always_comb begin
        req_ready = '0;
        sbox_in   = 6'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_vld_p0 && (gnt_id_p0 == IDW'(i))) begin
                req_ready[i] = 1'b1;
                sbox_in      = req_data[6*i +: 6];
            end
        end
    end

    // ---- stage p0 -> p1: launch the lookup and advance the round-robin pointer ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            id_p1  <= '0;
            rr_ptr <= '0;
        end else if (clear) begin
            vld_p1 <= 1'b0;
            rr_ptr <= '0;
        end else begin
            vld_p1 <= gnt_vld_p0;
            if (gnt_vld_p0) begin
                id_p1  <= gnt_id_p0;
                rr_ptr <= rr_next;
            end
        end
    end

    // ---- stage p1 -> response slots: capture the S-box result, release consumed slots ----
    // The write wins over a release of the same slot; data is kept until overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else if (clear) begin
            rsp_valid <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (vld_p1 && (id_p1 == IDW'(i))) begin
                    rsp_valid[i]      <= 1'b1;
                    rsp_data[6*i +: 6] <= sbox_out;
                end else if (rsp_valid[i] && rsp_ready[i]) begin
                    rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Completed-lookup counter; a flushed lookup is not counted. Wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lookup_cnt <= '0;
        end else if (vld_p1 && !clear) begin
            lookup_cnt <= lookup_cnt + CNTW'(1);
        end
    end

    assign busy = vld_p1 || (|rsp_valid);

endmodule

// File: tb/tb_odo_sbox6_arbiter.sv
// Testbench for odo_sbox6_arbiter: directed scenarios followed by random
// traffic, all compared cycle by cycle against a transaction-level model.
module tb_odo_sbox6_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int CNTW = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clear;
    logic [NREQ-1:0]   req_valid;
    logic [6*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [6*NREQ-1:0] rsp_data;
    logic [NREQ-1:0]   rsp_ready;
    logic [5:0]        sbox_in;
    logic [5:0]        sbox_out = 6'h00;
    logic              busy;
    logic [CNTW-1:0]   lookup_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    // External S-box contents
    logic [5:0] tbl [64];

    // Reference model state
    int         m_rr;
    bit         m_rv   [NREQ];
    logic [5:0] m_rd   [NREQ];
    bit         m_fl;
    int         m_fid;
    logic [5:0] m_fval;
    int         m_cnt;

    odo_sbox6_arbiter #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_ready  (rsp_ready),
        .sbox_in    (sbox_in),
        .sbox_out   (sbox_out),
        .busy       (busy),
        .lookup_cnt (lookup_cnt)
    );

    always #5 clk = ~clk;

    // Registered shared S-box
    always @(posedge clk) sbox_out <= tbl[sbox_in];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rr = 0; m_fl = 0; m_fid = 0; m_fval = 6'h00; m_cnt = 0;
        for (int i = 0; i < NREQ; i++) begin
            m_rv[i] = 0;
            m_rd[i] = 6'h00;
        end
    endtask

    function automatic int exp_grant();
        int idx;
        if (clear || !rst_n) return -1;
        for (int off = 0; off < NREQ; off++) begin
            idx = (m_rr + off) % NREQ;
            if (req_valid[idx] && (!m_rv[idx] || rsp_ready[idx]) && !(m_fl && m_fid == idx))
                return idx;
        end
        return -1;
    endfunction

    task automatic check_outputs(input int g);
        logic [NREQ-1:0] er;
        logic [5:0]      es;
        bit              eb;
        er = '0;
        es = 6'h00;
        if (g >= 0) begin
            er[g] = 1'b1;
            es    = req_data[6*g +: 6];
        end
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("sbox_in", 32'(sbox_in), 32'(es));
        eb = m_fl;
        for (int i = 0; i < NREQ; i++) begin
            if (m_rv[i]) eb = 1;
            chk($sformatf("rsp_valid[%0d]", i), 32'(rsp_valid[i]), 32'(m_rv[i]));
            chk($sformatf("rsp_data[%0d]", i), 32'(rsp_data[6*i +: 6]), 32'(m_rd[i]));
        end
        chk("busy", 32'(busy), 32'(eb));
        chk("lookup_cnt", 32'(lookup_cnt), 32'(m_cnt));
        chk("rr_ptr", 32'(dut.rr_ptr), 32'(m_rr));
    endtask

    // Advance the model across one clock edge using the inputs applied this cycle
    task automatic model_edge(input int g);
        if (clear) begin
            m_fl = 0;
            m_rr = 0;
            for (int i = 0; i < NREQ; i++) m_rv[i] = 0;
        end else begin
            for (int i = 0; i < NREQ; i++)
                if (m_rv[i] && rsp_ready[i]) m_rv[i] = 0;
            if (m_fl) begin
                m_rv[m_fid] = 1;
                m_rd[m_fid] = m_fval;
                m_cnt = (m_cnt + 1) % (1 << CNTW);
            end
            if (g >= 0) begin
                m_fl   = 1;
                m_fid  = g;
                m_fval = tbl[req_data[6*g +: 6]];
                m_rr   = (g + 1) % NREQ;
            end else begin
                m_fl = 0;
            end
        end
    endtask

    // Called just after a negedge with inputs already applied
    task automatic step();
        int g;
        #1;
        g = exp_grant();
        check_outputs(g);
        @(posedge clk);
        model_edge(g);
        @(negedge clk);
    endtask

    task automatic drive(input logic [NREQ-1:0] v, input logic [6*NREQ-1:0] d,
                         input logic [NREQ-1:0] rr, input logic c);
        req_valid = v;
        req_data  = d;
        rsp_ready = rr;
        clear     = c;
        step();
    endtask

    initial begin
        for (int x = 0; x < 64; x++) tbl[x] = 6'((x * 37 + 59) % 64);
        tbl[6'h00] = 6'h3b;
        tbl[6'h20] = 6'h12;
        tbl[6'h3f] = 6'h31;

        rst_n = 1'b0; clear = 1'b0;
        req_valid = '0; req_data = '0; rsp_ready = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        // Reset state, with a request pending to show ready stays low
        req_valid = 4'b0001;
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'h0);
        check_outputs(-1);
        @(negedge clk);
        req_valid = '0;
        rst_n = 1'b1;

        // Single lookup from requester 0 with data 0x00
        drive(4'b0001, '0, 4'h0, 1'b0);
        drive(4'b0000, '0, 4'h0, 1'b0);
        #1;
        chk("tp1_rsp_valid", 32'(rsp_valid[0]), 32'h1);
        chk("tp1_rsp_data", 32'(rsp_data[5:0]), 32'h3b);
        chk("tp1_cnt", 32'(lookup_cnt), 32'h1);
        drive(4'b0000, '0, 4'hf, 1'b0);
        drive(4'b0000, '0, 4'hf, 1'b0);

        // All requesters saturating with data 0x3f
        for (int c = 0; c < 12; c++) drive(4'hf, {4{6'h3f}}, 4'hf, 1'b0);
        for (int c = 0; c < 3; c++) drive(4'h0, '0, 4'hf, 1'b0);
        #1;
        chk("tp2_rsp_data0", 32'(rsp_data[5:0]), 32'h31);
        chk("tp2_rsp_data3", 32'(rsp_data[23:18]), 32'h31);

        // Requester 2 alone with back-pressure, then release
        for (int c = 0; c < 6; c++) drive(4'b0100, 24'(6'h20) << 12, 4'h0, 1'b0);
        #1;
        chk("tp3_hold_valid", 32'(rsp_valid[2]), 32'h1);
        chk("tp3_hold_data", 32'(rsp_data[17:12]), 32'h12);
        chk("tp3_blocked", 32'(req_ready), 32'h0);
        for (int c = 0; c < 3; c++) drive(4'b0100, 24'(6'h20) << 12, 4'b0100, 1'b0);
        for (int c = 0; c < 3; c++) drive(4'h0, '0, 4'hf, 1'b0);

        // Requesters 1 and 3 with rr_ptr at 2
        drive(4'b0010, 24'h2a << 6, 4'hf, 1'b0);
        for (int c = 0; c < 2; c++) drive(4'h0, '0, 4'hf, 1'b0);
        drive(4'b1010, 24'h123456, 4'hf, 1'b0);
        drive(4'b1010, 24'h654321, 4'hf, 1'b0);
        for (int c = 0; c < 3; c++) drive(4'h0, '0, 4'hf, 1'b0);
        #1;
        chk("tp4_rr_ptr", 32'(dut.rr_ptr), 32'h2);

        // Clear discards an in-flight lookup
        drive(4'b0001, 24'h3f, 4'hf, 1'b0);
        drive(4'b0000, '0, 4'hf, 1'b1);
        drive(4'b0000, '0, 4'hf, 1'b0);
        #1;
        chk("tp5_busy", 32'(busy), 32'h0);
        chk("tp5_rsp_valid", 32'(rsp_valid), 32'h0);

        // Asynchronous reset while responses are held
        for (int c = 0; c < 5; c++) drive(4'hf, 24'h0a5c3f, 4'h0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("tp6_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("tp6_busy", 32'(busy), 32'h0);
        chk("tp6_req_ready", 32'(req_ready), 32'h0);
        chk("tp6_sbox_in", 32'(sbox_in), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = '0;

        // Random traffic with occasional clear; the narrow counter wraps
        for (int c = 0; c < 400; c++) begin
            drive(NREQ'($urandom), 24'($urandom), NREQ'($urandom | $urandom),
                  ($urandom_range(0, 19) == 0));
        end
        for (int c = 0; c < 4; c++) drive(4'h0, '0, 4'hf, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
